// File: rtl/branch_predictor_if.sv
// Branch predictor bus: fetch-side lookup and execute-side training/resolve.
//   FetchPC               - PC of the instruction in IF
//   PredictTaken          - lookup hit on a taken-biased entry
//   PredictTarget         - predicted next PC
//   UpdateEnable          - EX resolves a conditional branch this cycle
//   UpdatePC              - PC of the resolving branch
//   UpdateTaken           - resolved outcome
//   UpdateTarget          - resolved branch target
//   UpdatePredictedTaken  - prediction carried down the pipeline
//   UpdatePredictedTarget - predicted target carried down the pipeline
//   Mispredict            - resolving branch was mispredicted
// master: core side (drives fetch/update); slave: predictor.
interface branch_predictor_if;
    logic [31:0] FetchPC;
    logic        PredictTaken;
    logic [31:0] PredictTarget;
    logic        UpdateEnable;
    logic [31:0] UpdatePC;
    logic        UpdateTaken;
    logic [31:0] UpdateTarget;
    logic        UpdatePredictedTaken;
    logic [31:0] UpdatePredictedTarget;
    logic        Mispredict;

    modport master (
        output FetchPC, UpdateEnable, UpdatePC, UpdateTaken, UpdateTarget,
               UpdatePredictedTaken, UpdatePredictedTarget,
        input  PredictTaken, PredictTarget, Mispredict
    );

    modport slave (
        input  FetchPC, UpdateEnable, UpdatePC, UpdateTaken, UpdateTarget,
               UpdatePredictedTaken, UpdatePredictedTarget,
        output PredictTaken, PredictTarget, Mispredict
    );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating counters.
// Ports:
//   clk   - core clock, table written on rising edge
//   reset - asynchronous active-high; invalidates all entries, counters to 01
//   bus   - branch_predictor_if.slave (fetch lookup, EX training, Mispredict)
// Lookup is combinational and reads the table contents before any write in
// the same cycle. Tag/target storage is not reset; valid gates it from outputs.
module branch_predictor #(
    parameter int INDEX_BITS = 4
) (
    input  logic               clk,
    input  logic               reset,
    branch_predictor_if.slave  bus
);
    localparam int unsigned ENTRIES = 2 ** INDEX_BITS;
    localparam int TAG_W = 32 - INDEX_BITS - 2;

    logic              valid_q   [ENTRIES];
    logic [1:0]        counter_q [ENTRIES];
    logic [TAG_W-1:0]  tag_q     [ENTRIES];
    logic [31:0]       target_q  [ENTRIES];

    logic [INDEX_BITS-1:0] f_idx;
    logic [TAG_W-1:0]      f_tag;
    logic                  f_hit;
    logic [INDEX_BITS-1:0] u_idx;
    logic [TAG_W-1:0]      u_tag;
    logic                  u_hit;
    logic                  unused_pc_bits;

    assign f_idx = bus.FetchPC[INDEX_BITS+1:2];
    assign f_tag = bus.FetchPC[31:INDEX_BITS+2];
    assign u_idx = bus.UpdatePC[INDEX_BITS+1:2];
    assign u_tag = bus.UpdatePC[31:INDEX_BITS+2];
    assign unused_pc_bits = ^bus.UpdatePC[1:0];

    assign f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

    assign bus.PredictTaken  = f_hit && counter_q[f_idx][1];
    assign bus.PredictTarget = bus.PredictTaken ? target_q[f_idx]
                                                : bus.FetchPC + 32'd4;

    assign bus.Mispredict = bus.UpdateEnable &&
        ((bus.UpdateTaken != bus.UpdatePredictedTaken) ||
         (bus.UpdateTaken && (bus.UpdatePredictedTarget != bus.UpdateTarget)));

    // Valid bits and counters: reset-cleared state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                valid_q[i]   <= 1'b0;
                counter_q[i] <= 2'b01;
            end
        end else if (bus.UpdateEnable) begin
            if (u_hit) begin
                if (bus.UpdateTaken) begin
                    if (counter_q[u_idx] != 2'b11)
                        counter_q[u_idx] <= counter_q[u_idx] + 2'd1;
                end else begin
                    if (counter_q[u_idx] != 2'b00)
                        counter_q[u_idx] <= counter_q[u_idx] - 2'd1;
                end
            end else if (bus.UpdateTaken) begin
                valid_q[u_idx]   <= 1'b1;
                counter_q[u_idx] <= 2'b10;
            end
        end
    end

    // Tag and target: any taken update writes them (on a hit the tag is
    // already equal), so hit and allocate share one write path.
    always_ff @(posedge clk) begin
        if (!reset && bus.UpdateEnable && bus.UpdateTaken) begin
            tag_q[u_idx]    <= u_tag;
            target_q[u_idx] <= bus.UpdateTarget;
        end
    end
endmodule

// File: doc/branch_predictor.md
# branch_predictor

Branch target buffer with 2-bit saturating counters for the pipelined MIPS core. In IF it predicts, from the fetch PC, whether the instruction is a taken branch and supplies the next-PC candidate. In EX it is trained by the resolved branch outcome (the BEQ/BNE decision), and it flags mispredictions so the hazard logic can flush.

## Interface
- INDEX_BITS, 4: table has 2**INDEX_BITS entries; index = PC[INDEX_BITS+1:2]
- clk  input  1  core clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears the table
- FetchPC  input  32  PC of the instruction in IF
- PredictTaken  output  1  1 when FetchPC hits a valid entry whose counter is 2'b10 or 2'b11
- PredictTarget  output  32  stored target when PredictTaken is 1, else FetchPC + 4
- UpdateEnable  input  1  EX holds a resolved conditional branch this cycle
- UpdatePC  input  32  PC of the resolved branch
- UpdateTaken  input  1  resolved outcome (branch control signal)
- UpdateTarget  input  32  computed branch target
- UpdatePredictedTaken  input  1  PredictTaken value carried down the pipeline for this branch
- UpdatePredictedTarget  input  32  PredictTarget value carried down the pipeline
- Mispredict  output  1  combinational; prediction for the resolving branch was wrong

## Operation
- Entry fields: valid (1), tag = PC[31:INDEX_BITS+2], target (32), counter (2).
- Counter encoding: 00 strongly not-taken, 01 weakly not-taken, 10 weakly taken, 11 strongly taken.
- Lookup is combinational on FetchPC.
  - Hit = valid & tag match.
  - PredictTaken = hit & counter[1].
  - PredictTarget = PredictTaken ? target : FetchPC + 4, wrapping modulo 2**32.
- Update occurs only when UpdateEnable = 1 and is applied at the rising edge.
  - Hit on UpdatePC, taken: counter saturating-increments (11 stays 11); target <= UpdateTarget.
  - Hit, not taken: counter saturating-decrements (00 stays 00); target unchanged.
  - Miss (invalid entry or tag mismatch), taken: allocate, overwriting any aliasing entry. valid <= 1, tag <= UpdatePC tag, target <= UpdateTarget, counter <= 10.
  - Miss, not taken: no table change.
- Mispredict = UpdateEnable & ((UpdateTaken != UpdatePredictedTaken) | (UpdateTaken & UpdatePredictedTarget != UpdateTarget)). It is 0 when UpdateEnable = 0.
- Index and tag ignore PC[1:0].

## Timing
- Reset, asserted asynchronously at any time, including mid-update:
  - all valid bits <= 0 and all counters <= 01 immediately.
  - PredictTaken = 0 and PredictTarget = FetchPC + 4 while reset is high and afterwards until the first allocation.
  - Mispredict is combinational and is not gated by reset.
- Lookup latency is 0 cycles. Update becomes visible to lookup on the cycle after the clock edge that writes it.
- Simultaneous lookup and update of the same index in one cycle: the lookup returns the pre-update contents (read-old).
- One update per cycle. No stalls; the block never backpressures.
- No X on outputs after reset. Target and tag storage may be uninitialised, but must not reach outputs while valid = 0.

## Test plan
- Reset state: assert reset, FetchPC = 0x00400010 -> PredictTaken = 0, PredictTarget = 0x00400014. Repeat for all 16 indices.
- Allocation: UpdateEnable = 1, UpdatePC = 0x00400010, UpdateTaken = 1, UpdateTarget = 0x00400040, UpdatePredictedTaken = 0.
  - Same cycle: Mispredict = 1.
  - Next cycle with FetchPC = 0x00400010: PredictTaken = 1, PredictTarget = 0x00400040.
- Saturation and hysteresis: from counter 10, apply taken twice -> counter 11 stays 11. Then one not-taken -> still predicts taken (10). Second not-taken -> PredictTaken = 0 (01). Two more not-taken -> 00, no underflow.
- Aliasing: with 0x00400010 allocated, a taken update at 0x00400050 (same index 4, different tag, target 0x00400100) replaces the entry.
  - FetchPC = 0x00400010 -> PredictTaken = 0, target 0x00400014.
  - FetchPC = 0x00400050 -> PredictTarget = 0x00400100.
  - A not-taken update to an unallocated PC leaves the table unchanged.
- Same-cycle read/write and target mispredict:
  - Update and FetchPC on the same index in one cycle -> lookup shows old value, new value the next cycle.
  - UpdateTaken = 1, predicted taken, UpdatePredictedTarget = 0x00400040, UpdateTarget = 0x00400080 -> Mispredict = 1, stored target becomes 0x00400080.
- Reset mid-operation: assert reset asynchronously between clock edges after several allocations -> PredictTaken drops to 0 without waiting for a clock edge. All entries invalid after release; an update coincident with reset has no effect.
